// File: rtl/beat_ctrl_seq.sv
// Hardwired controller for the 4-bit-opcode teaching CPU with an internal one-hot
// beat generator (W1/W2/W3), console-mode sequencer, halt handshake and retired counter.
module beat_ctrl_seq #(
  parameter int CNT_W    = 16,
  parameter bit AUTO_RUN = 1'b0
) (
  input  logic             t3,
  input  logic             clr,
  input  logic             start,
  input  logic [2:0]       sw,
  input  logic [3:0]       ir,
  input  logic             c,
  input  logic             z,
  input  logic             halt_req,
  output logic             halt_ack,
  output logic [2:0]       w,
  output logic             st0,
  output logic [3:0]       s,
  output logic             m,
  output logic             cin,
  output logic [17:0]      ctl,
  output logic [3:0]       sel,
  output logic [CNT_W-1:0] icnt
);

  typedef enum logic [2:0] {S_IDLE, S_W1, S_W2, S_W3, S_HALT} state_t;

  state_t     state;
  logic [2:0] mode_q;
  logic [2:0] mode;
  logic       lir, pcinc, drw, ldz, ldc, abus, sbus, mbus, lar, arinc;
  logic       lpc, pcadd, memw, selctl, cyc_short, cyc_long, stop;
  logic       end_cyc, run_cyc;

  // Mode is sampled live in W1 and frozen for the rest of the cycle, so a
  // console switch change only lands on a cycle boundary.
  always_comb begin
    {lir, pcinc, drw, ldz, ldc, abus, sbus, mbus, lar} = 9'b0;
    {arinc, lpc, pcadd, memw, selctl, cyc_short, cyc_long, stop} = 8'b0;
    s    = 4'b0000;
    m    = 1'b0;
    cin  = 1'b0;
    sel  = 4'b0000;
    mode = (state == S_W1) ? sw : mode_q;
    if (state == S_W1 || state == S_W2 || state == S_W3) begin
      case (mode)
        3'b000: begin
          if (!st0) begin
            if (state == S_W1) {sbus, lpc, cyc_short, stop} = 4'b1111;
          end else if (state == S_W1) begin
            {lir, pcinc} = 2'b11;
          end else if (state == S_W2) begin
            case (ir)
              4'h1: begin {abus, drw, ldz, ldc} = 4'b1111; s = 4'b1001; cin = 1'b1; end
              4'h2: begin {abus, drw, ldz, ldc} = 4'b1111; s = 4'b0110; end
              4'h3: begin {abus, drw, ldz} = 3'b111; s = 4'b1011; m = 1'b1; end
              4'h4: begin {abus, drw, ldz, ldc} = 4'b1111; end
              4'ha: begin {abus, drw, ldz} = 3'b111; s = 4'b0110; m = 1'b1; end
              4'hb: begin {abus, drw, ldz, ldc} = 4'b1111; s = 4'b1111; cin = 1'b1; end
              4'h5, 4'h6: begin {abus, lar, cyc_long} = 3'b111; s = 4'b1010; m = 1'b1; end
              4'h7: pcadd = c;
              4'h8: pcadd = z;
              4'h9: begin {abus, lpc} = 2'b11; s = 4'b1111; m = 1'b1; end
              4'he: stop = 1'b1;
              default: ;
            endcase
          end else begin
            if (ir == 4'h5) {mbus, drw} = 2'b11;
            else if (ir == 4'h6) begin {abus, memw} = 2'b11; s = 4'b1111; m = 1'b1; end
          end
        end
        3'b100: begin
          {selctl, sbus, drw, stop} = 4'b1111;
          sel = (state == S_W1) ? {st0, 3'b001} : {st0, 3'b110};
        end
        3'b011: begin
          {selctl, stop} = 2'b11;
          sel = (state == S_W1) ? 4'b0001 : 4'b1011;
        end
        3'b010, 3'b001: begin
          {cyc_short, stop} = 2'b11;
          if (!st0)                {sbus, lar} = 2'b11;
          else if (mode == 3'b010) {mbus, arinc} = 2'b11;
          else                     {sbus, memw, arinc} = 3'b111;
        end
        default: stop = 1'b1;
      endcase
    end
    end_cyc = (state == S_W1 && cyc_short) || (state == S_W2 && !cyc_long) || (state == S_W3);
    run_cyc = (mode == 3'b000) && st0;
  end

  assign ctl = {lir, pcinc, drw, ldz, ldc, abus, sbus, mbus, lar, arinc,
                lpc, pcadd, memw, selctl, cyc_short, cyc_long, stop, 1'b0};
  assign halt_ack = (state == S_HALT);
  assign w = {state == S_W3, state == S_W2, state == S_W1};

  always_ff @(posedge t3 or posedge clr) begin
    if (clr) begin
      state  <= S_IDLE;
      st0    <= 1'b0;
      icnt   <= '0;
      mode_q <= 3'b000;
    end else begin
      if (state == S_W1) mode_q <= sw;
      case (state)
        S_IDLE: if (start || AUTO_RUN) state <= S_W1;
        S_HALT: if (start && !halt_req) state <= S_W1;
        S_W1:   if (!cyc_short) state <= S_W2;
        S_W2:   if (cyc_long) state <= S_W3;
        S_W3:   ;
        default: state <= S_IDLE;
      endcase
      if (end_cyc) begin
        state <= (stop || halt_req) ? S_HALT : S_W1;
        if (run_cyc) icnt <= icnt + CNT_W'(1);
        if (mode == 3'b100) begin
          if (state == S_W2) st0 <= ~st0;
        end else if (mode == 3'b000 || mode == 3'b010 || mode == 3'b001) begin
          st0 <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_beat_ctrl_seq.sv
// Self-checking bench for beat_ctrl_seq: opcode vector table, directed console/halt/reset
// sequences, and a randomized instruction stream against a cycle-level reference.
module tb_beat_ctrl_seq;

  logic        t3 = 1'b0, clr, start, c, z, halt_req;
  logic [2:0]  sw;
  logic [3:0]  ir;
  logic        halt_ack, st0, m, cin;
  logic [2:0]  w;
  logic [3:0]  s, sel;
  logic [17:0] ctl;
  logic [3:0]  icnt;

  beat_ctrl_seq #(.CNT_W(4), .AUTO_RUN(1'b0)) dut (
    .t3(t3), .clr(clr), .start(start), .sw(sw), .ir(ir), .c(c), .z(z),
    .halt_req(halt_req), .halt_ack(halt_ack), .w(w), .st0(st0), .s(s), .m(m),
    .cin(cin), .ctl(ctl), .sel(sel), .icnt(icnt)
  );

  always #5 t3 = ~t3;

  localparam logic [17:0] LIR = 18'h20000, PCINC = 18'h10000, DRW = 18'h08000, LDZ = 18'h04000,
    LDC = 18'h02000, ABUS = 18'h01000, SBUS = 18'h00800, MBUS = 18'h00400, LAR = 18'h00200,
    ARINC = 18'h00100, LPC = 18'h00080, PCADD = 18'h00040, MEMW = 18'h00020, SELCTL = 18'h00010,
    SHORT = 18'h00008, LONG = 18'h00004, STOP = 18'h00002;

  typedef struct {
    logic [3:0]  op;
    logic        c, z;
    logic [23:0] w2;
    logic        three;
    logic [23:0] w3;
  } vec_t;

  vec_t tv [0:15];
  int   errors = 0, checks = 0, exp_icnt = 0;
  bit   exp_st0, in_halt;

  function automatic logic [23:0] mk(logic [17:0] k, logic [3:0] s_, logic m_, logic cin_);
    return {k, s_, m_, cin_};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge t3);
    #1;
  endtask

  function automatic logic [23:0] cw();
    return {ctl, s, m, cin};
  endfunction

  // Runs one RUN-mode instruction from HALT and expects it to halt at its boundary.
  task automatic run_vec(input int i);
    ir = tv[i].op; c = tv[i].c; z = tv[i].z;
    halt_req = 1'b0; start = 1'b1;
    step();
    start = 1'b0; halt_req = 1'b1;
    chk("tab_w1_beat", w, 3'b001);
    chk("tab_w1_ctl", cw(), mk(LIR | PCINC, 4'h0, 1'b0, 1'b0));
    step();
    chk("tab_w2_beat", w, 3'b010);
    chk("tab_w2_ctl", cw(), tv[i].w2);
    if (tv[i].three) begin
      step();
      chk("tab_w3_beat", w, 3'b100);
      chk("tab_w3_ctl", cw(), tv[i].w3);
    end
    step();
    exp_icnt = (exp_icnt + 1) % 16;
    chk("tab_halt_ack", halt_ack, 1'b1);
    chk("tab_halt_beat", w, 3'b000);
    chk("tab_icnt", icnt, exp_icnt);
  endtask

  // Console cycle from HALT/IDLE: one or two beats, then HALT.
  task automatic console(input string name, input logic [2:0] mode, input int beats,
                         input logic [23:0] e1, input logic [3:0] s1,
                         input logic [23:0] e2, input logic [3:0] s2);
    sw = mode; halt_req = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    chk({name, "_w1"}, w, 3'b001);
    chk({name, "_w1_ctl"}, cw(), e1);
    chk({name, "_w1_sel"}, sel, s1);
    if (beats == 2) begin
      step();
      chk({name, "_w2"}, w, 3'b010);
      chk({name, "_w2_ctl"}, cw(), e2);
      chk({name, "_w2_sel"}, sel, s2);
    end
    step();
    chk({name, "_halt"}, halt_ack, 1'b1);
  endtask

  initial begin
    tv[0]  = '{4'h1, 1'b0, 1'b0, mk(ABUS | DRW | LDZ | LDC, 4'b1001, 1'b0, 1'b1), 1'b0, 24'h0};
    tv[1]  = '{4'h2, 1'b0, 1'b0, mk(ABUS | DRW | LDZ | LDC, 4'b0110, 1'b0, 1'b0), 1'b0, 24'h0};
    tv[2]  = '{4'h3, 1'b0, 1'b0, mk(ABUS | DRW | LDZ, 4'b1011, 1'b1, 1'b0), 1'b0, 24'h0};
    tv[3]  = '{4'h4, 1'b0, 1'b0, mk(ABUS | DRW | LDZ | LDC, 4'b0000, 1'b0, 1'b0), 1'b0, 24'h0};
    tv[4]  = '{4'ha, 1'b0, 1'b0, mk(ABUS | DRW | LDZ, 4'b0110, 1'b1, 1'b0), 1'b0, 24'h0};
    tv[5]  = '{4'hb, 1'b0, 1'b0, mk(ABUS | DRW | LDZ | LDC, 4'b1111, 1'b0, 1'b1), 1'b0, 24'h0};
    tv[6]  = '{4'h5, 1'b0, 1'b0, mk(ABUS | LAR | LONG, 4'b1010, 1'b1, 1'b0), 1'b1,
               mk(MBUS | DRW, 4'h0, 1'b0, 1'b0)};
    tv[7]  = '{4'h6, 1'b0, 1'b0, mk(ABUS | LAR | LONG, 4'b1010, 1'b1, 1'b0), 1'b1,
               mk(ABUS | MEMW, 4'b1111, 1'b1, 1'b0)};
    tv[8]  = '{4'h7, 1'b0, 1'b1, 24'h0, 1'b0, 24'h0};
    tv[9]  = '{4'h7, 1'b1, 1'b0, mk(PCADD, 4'h0, 1'b0, 1'b0), 1'b0, 24'h0};
    tv[10] = '{4'h8, 1'b0, 1'b1, mk(PCADD, 4'h0, 1'b0, 1'b0), 1'b0, 24'h0};
    tv[11] = '{4'h8, 1'b1, 1'b0, 24'h0, 1'b0, 24'h0};
    tv[12] = '{4'h9, 1'b0, 1'b0, mk(ABUS | LPC, 4'b1111, 1'b1, 1'b0), 1'b0, 24'h0};
    tv[13] = '{4'h0, 1'b0, 1'b0, 24'h0, 1'b0, 24'h0};
    tv[14] = '{4'hf, 1'b1, 1'b1, 24'h0, 1'b0, 24'h0};
    tv[15] = '{4'he, 1'b0, 1'b0, mk(STOP, 4'h0, 1'b0, 1'b0), 1'b0, 24'h0};

    clr = 1'b1; start = 1'b0; sw = 3'b000; ir = 4'h0; c = 1'b0; z = 1'b0; halt_req = 1'b0;
    #1;
    chk("rst_w", w, 3'b000);
    chk("rst_st0", st0, 1'b0);
    chk("rst_icnt", icnt, 4'h0);
    chk("rst_halt_ack", halt_ack, 1'b0);
    chk("rst_ctl", cw(), 24'h0);
    step();
    clr = 1'b0;
    repeat (3) step();
    chk("idle_wait_w", w, 3'b000);

    // RUN bootstrap: st0=0 loads PC and stops.
    start = 1'b1;
    step();
    start = 1'b0;
    chk("boot_w1", w, 3'b001);
    chk("boot_ctl", cw(), mk(SBUS | LPC | SHORT | STOP, 4'h0, 1'b0, 1'b0));
    step();
    chk("boot_halt", halt_ack, 1'b1);
    chk("boot_st0", st0, 1'b1);
    chk("boot_icnt", icnt, 4'h0);

    for (int i = 0; i < 16; i++) run_vec(i);

    // halt_req raised mid-instruction only takes effect at the boundary.
    ir = 4'h2; halt_req = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    chk("hreq_w1", w, 3'b001);
    step();
    halt_req = 1'b1;
    chk("hreq_w2_sub", cw(), tv[1].w2);
    step();
    exp_icnt = (exp_icnt + 1) % 16;
    chk("hreq_halt_ack", halt_ack, 1'b1);
    chk("hreq_icnt", icnt, exp_icnt);
    start = 1'b1;
    step();
    chk("hreq_start_ignored", halt_ack, 1'b1);
    halt_req = 1'b0;
    step();
    start = 1'b0;
    chk("resume_w1", w, 3'b001);
    chk("resume_ack_low", halt_ack, 1'b0);
    step();
    step();
    exp_icnt = (exp_icnt + 1) % 16;
    chk("free_run_next_w1", w, 3'b001);
    halt_req = 1'b1;
    step();
    step();
    exp_icnt = (exp_icnt + 1) % 16;
    chk("free_run_halt", halt_ack, 1'b1);
    chk("free_run_icnt", icnt, exp_icnt);

    // Random instruction stream; the model tracks beat count, halting and icnt.
    in_halt = 1'b1;
    for (int n = 0; n < 40; n++) begin
      int idx;
      bit hr;
      idx = $urandom_range(0, 15);
      hr = (n == 39) || ($urandom_range(0, 3) == 0);
      ir = tv[idx].op; c = tv[idx].c; z = tv[idx].z;
      if (in_halt) begin
        halt_req = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
      end
      halt_req = hr;
      chk("rnd_w1", w, 3'b001);
      chk("rnd_w1_ctl", cw(), mk(LIR | PCINC, 4'h0, 1'b0, 1'b0));
      step();
      chk("rnd_w2_ctl", cw(), tv[idx].w2);
      if (tv[idx].three) begin
        step();
        chk("rnd_w3_ctl", cw(), tv[idx].w3);
      end
      step();
      exp_icnt = (exp_icnt + 1) % 16;
      in_halt = hr || (tv[idx].op == 4'he);
      chk("rnd_halt_ack", halt_ack, in_halt);
      chk("rnd_icnt", icnt, exp_icnt);
    end

    // Asynchronous clear in W2 of LD.
    ir = 4'h5; halt_req = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("ld_w2_before_clr", w, 3'b010);
    #2 clr = 1'b1;
    #1;
    chk("clr_w", w, 3'b000);
    chk("clr_st0", st0, 1'b0);
    chk("clr_icnt", icnt, 4'h0);
    chk("clr_ctl", cw(), 24'h0);
    #1 clr = 1'b0;
    repeat (2) step();
    chk("clr_idle", {halt_ack, w}, 4'b0000);
    exp_icnt = 0;

    // WREG: four starts walk both register pairs; sw change mid-cycle is ignored.
    exp_st0 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sw = 3'b100; halt_req = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      chk("wreg_w1_sel", sel, {exp_st0, 3'b001});
      chk("wreg_w1_ctl", cw(), mk(SELCTL | SBUS | DRW | STOP, 4'h0, 1'b0, 1'b0));
      step();
      if (k == 1) sw = 3'b000;
      #1;
      chk("wreg_w2_sel", sel, {exp_st0, 3'b110});
      chk("wreg_w2_ctl", cw(), mk(SELCTL | SBUS | DRW | STOP, 4'h0, 1'b0, 1'b0));
      step();
      exp_st0 = ~exp_st0;
      chk("wreg_halt", halt_ack, 1'b1);
      chk("wreg_st0", st0, exp_st0);
    end

    console("rreg", 3'b011, 2, mk(SELCTL | STOP, 4'h0, 1'b0, 1'b0), 4'b0001,
            mk(SELCTL | STOP, 4'h0, 1'b0, 1'b0), 4'b1011);
    chk("rreg_st0", st0, 1'b0);
    console("rmem0", 3'b010, 1, mk(SBUS | LAR | SHORT | STOP, 4'h0, 1'b0, 1'b0), 4'h0, 24'h0, 4'h0);
    chk("rmem0_st0", st0, 1'b1);
    console("rmem1", 3'b010, 1, mk(MBUS | ARINC | SHORT | STOP, 4'h0, 1'b0, 1'b0), 4'h0, 24'h0, 4'h0);
    console("wmem1", 3'b001, 1, mk(SBUS | MEMW | ARINC | SHORT | STOP, 4'h0, 1'b0, 1'b0), 4'h0,
            24'h0, 4'h0);
    console("other", 3'b111, 2, mk(STOP, 4'h0, 1'b0, 1'b0), 4'h0, mk(STOP, 4'h0, 1'b0, 1'b0), 4'h0);
    chk("console_icnt", icnt, 4'h0);

    // Counter wrap: 17 NOPs on a 4-bit counter.
    clr = 1'b1;
    step();
    clr = 1'b0; sw = 3'b000;
    start = 1'b1;
    step();
    step();
    chk("wrap_boot_st0", st0, 1'b1);
    ir = 4'h0; halt_req = 1'b0;
    step();
    start = 1'b0;
    repeat (34) step();
    chk("wrap_w1", w, 3'b001);
    chk("wrap_icnt", icnt, 4'h1);
    halt_req = 1'b1;
    step();
    step();
    chk("wrap_halt", halt_ack, 1'b1);
    chk("wrap_icnt2", icnt, 4'h2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
